// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues SRAM-like req/addr_ok/data_ok accesses, aligns load data, flags alignment faults.
// Latency: req in the issue cycle itself; load_data registered in the data_ok cycle.
// Backpressure: stall_req freezes upstream while an access is outstanding; stall_hold parks a finished access in DONE.
module mem_dbus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_din,
  input  logic [4:0]        mem_exccode,
  input  logic              flush,
  input  logic              stall_hold,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              stall_req,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [4:0] EXC_NONE = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q;
  logic              wr_q, sext_q, flush_seen_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_data_q;

  logic              is_load, is_store, ld_sext, misaligned, exc_clear, issue, flushed;
  logic [1:0]        op_size, cur_size, cur_off;
  logic              cur_sext;
  logic [DATA_W-1:0] store_wdata, load_aligned;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Decode the memory op into direction, access size and load signedness.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_size  = 2'd0;
    ld_sext  = 1'b0;
    case (mem_aluop)
      OP_LB:   begin is_load = 1'b1; ld_sext = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; end
      OP_LH:   begin is_load = 1'b1; op_size = 2'd1; ld_sext = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; op_size = 2'd1; end
      OP_LW:   begin is_load = 1'b1; op_size = 2'd2; end
      OP_SB:   begin is_store = 1'b1; end
      OP_SH:   begin is_store = 1'b1; op_size = 2'd1; end
      OP_SW:   begin is_store = 1'b1; op_size = 2'd2; end
      default: ;
    endcase
  end

  assign misaligned = ((op_size == 2'd1) && mem_wd[0]) ||
                      ((op_size == 2'd2) && (mem_wd[1:0] != 2'b00));
  assign exc_clear  = (mem_exccode == EXC_NONE);
  assign adel       = is_load  && misaligned && exc_clear;
  assign ades       = is_store && misaligned && exc_clear;
  assign badvaddr   = (adel || ades) ? mem_wd : '0;
  assign issue      = (is_load || is_store) && exc_clear && !misaligned && !flush && !cpu_rst;
  // A flush seen anywhere while the request is pending dooms the response.
  assign flushed    = flush || flush_seen_q;

  // Replicate store data across all byte lanes so the slave can pick any lane.
  always_comb begin
    case (op_size)
      2'd0:    store_wdata = {4{mem_din[7:0]}};
      2'd1:    store_wdata = {2{mem_din[15:0]}};
      default: store_wdata = mem_din;
    endcase
  end

  // Align and extend read data; IDLE uses live inputs (same-cycle completion), other states the latched copy.
  always_comb begin
    cur_size = (state_q == S_IDLE) ? op_size     : size_q;
    cur_sext = (state_q == S_IDLE) ? ld_sext     : sext_q;
    cur_off  = (state_q == S_IDLE) ? mem_wd[1:0] : addr_q[1:0];
    case (cur_off)
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      2'd3:    byte_sel = data_rdata[31:24];
      default: byte_sel = data_rdata[7:0];
    endcase
    half_sel = cur_off[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (cur_size)
      2'd0:    load_aligned = {{24{cur_sext & byte_sel[7]}}, byte_sel};
      2'd1:    load_aligned = {{16{cur_sext & half_sel[15]}}, half_sel};
      default: load_aligned = data_rdata;
    endcase
  end

  // Bus outputs and stall: live request in IDLE, latched request while pending.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    stall_req  = 1'b0;
    if (state_q != S_IDLE) begin
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
    end
    case (state_q)
      S_IDLE: if (issue) begin
        data_req   = 1'b1;
        data_wr    = is_store;
        data_size  = op_size;
        data_addr  = mem_wd;
        data_wdata = store_wdata;
        stall_req  = !(data_addr_ok && data_data_ok);
      end
      S_REQ:   begin data_req = 1'b1; stall_req = 1'b1; end
      S_WAIT:  stall_req = !data_data_ok;
      // Stay stalled through the drain so the instruction now in MEM is not skipped.
      S_DRAIN: stall_req = 1'b1;
      default: ;
    endcase
  end

  // Access FSM: request capture, flush tracking and load result register.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      sext_q       <= 1'b0;
      flush_seen_q <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (issue) begin
          wr_q         <= is_store;
          sext_q       <= ld_sext;
          size_q       <= op_size;
          addr_q       <= mem_wd;
          wdata_q      <= store_wdata;
          flush_seen_q <= 1'b0;
          if (!data_addr_ok) begin
            state_q <= S_REQ;
          end else if (!data_data_ok) begin
            state_q <= S_WAIT;
          end else begin
            if (is_load) load_data_q <= load_aligned;
            state_q <= stall_hold ? S_DONE : S_IDLE;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            if (!data_data_ok) begin
              state_q <= flushed ? S_DRAIN : S_WAIT;
            end else if (flushed) begin
              state_q <= S_IDLE;
            end else begin
              if (!wr_q) load_data_q <= load_aligned;
              state_q <= stall_hold ? S_DONE : S_IDLE;
            end
          end else if (flush) begin
            flush_seen_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (!flush) begin
              if (!wr_q) load_data_q <= load_aligned;
              state_q <= stall_hold ? S_DONE : S_IDLE;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DONE:  if (!stall_hold || flush) state_q <= S_IDLE;
        S_DRAIN: if (data_data_ok) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_data = load_data_q;

endmodule
